// File: rtl/board_mine_placer_if.sv
// Single-master Wishbone write channel between the mine placer and the board memory.
// Latency: none (wires only).
// Backpressure: slave holds stall_i to freeze a request; ack_i closes each transfer.
interface wishbone_if;
    logic [7:0] adr_o;
    logic [7:0] dat_o;
    logic       we_o;
    logic       stb_o;
    logic       cyc_o;
    logic       stall_i;
    logic       ack_i;

    modport master (
        output adr_o,
        output dat_o,
        output we_o,
        output stb_o,
        output cyc_o,
        input  stall_i,
        input  ack_i
    );

    modport slave (
        input  adr_o,
        input  dat_o,
        input  we_o,
        input  stb_o,
        input  cyc_o,
        output stall_i,
        output ack_i
    );
endinterface

// File: rtl/board_mine_placer.sv
// Places mines with an LFSR into a 16x16 bitmap and writes every encoded board cell over Wishbone.
// Latency: 1 accept cycle + placement cycles + 2 cycles per cell (256 cells) + 1 finish cycle.
// Backpressure: stall_i freezes the pending request; one outstanding write, waits on ack_i forever.
module board_mine_placer #(
    parameter int          BOARD_SIZE    = 16,
    parameter logic [15:0] LFSR_ALT_SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] seed,
    input  logic [4:0]  board_dim,
    input  logic [7:0]  mine_count,
    output logic        busy,
    output logic        done,
    output logic        error,
    wishbone_if.master  master_wr
);

    localparam logic [4:0]  MAX_DIM  = 5'(BOARD_SIZE);
    localparam logic [4:0]  MIN_DIM  = 5'd2;
    localparam logic [15:0] LFSR_TAP = 16'hB400;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PLACE,
        S_WR_REQ,
        S_WR_ACK,
        S_FINISH
    } state_t;

    state_t         state;
    logic [15:0]    lfsr;
    logic [255:0]   bitmap;
    logic [7:0]     placed;
    logic [7:0]     mines_q;
    logic [4:0]     dim_q;
    logic [7:0]     cell_idx;

    logic [15:0]    lfsr_next;
    logic [7:0]     cand;
    logic           cand_ok;
    logic [9:0]     dim_sq;
    logic           start_bad;
    logic [7:0]     enc_idx;
    logic [7:0]     enc_dat;

    // Encoded byte for one cell: mine flag in bit 7, otherwise the count of
    // in-board neighbour mines; cells outside the active square read as zero.
    // Neighbours are clipped at the board edge, never wrapped.
    function automatic logic [7:0] encode_cell(
        input logic [7:0]   idx,
        input logic [255:0] bm,
        input logic [4:0]   dim
    );
        logic [7:0] result;
        logic [7:0] nidx;
        logic [3:0] cnt;
        int         r;
        int         c;
        int         d;
        int         nr;
        int         nc;
        r      = int'(idx[7:4]);
        c      = int'(idx[3:0]);
        d      = int'(dim);
        cnt    = 4'd0;
        result = 8'h00;
        for (int dr = -1; dr <= 1; dr++) begin
            for (int dc = -1; dc <= 1; dc++) begin
                nr   = r + dr;
                nc   = c + dc;
                nidx = 8'(((nr & 15) * 16) + (nc & 15));
                if ((dr != 0 || dc != 0) && nr >= 0 && nc >= 0 &&
                    nr < d && nc < d && bm[nidx]) begin
                    cnt = cnt + 4'd1;
                end
            end
        end
        if (r < d && c < d) begin
            result = bm[idx] ? 8'h80 : {4'h0, cnt};
        end
        return result;
    endfunction

    // Galois LFSR step (x^16+x^14+x^13+x^11+1, right shift) and placement candidate test
    always_comb begin
        lfsr_next = {1'b0, lfsr[15:1]};
        if (lfsr[0]) begin
            lfsr_next = {1'b0, lfsr[15:1]} ^ LFSR_TAP;
        end
        cand    = lfsr[7:0];
        cand_ok = ({1'b0, cand[7:4]} < dim_q) &&
                  ({1'b0, cand[3:0]} < dim_q) &&
                  !bitmap[cand];
    end

    // Start validation: dimension range and at least one free cell left over
    always_comb begin
        dim_sq    = {5'd0, board_dim} * {5'd0, board_dim};
        start_bad = (board_dim < MIN_DIM) || (board_dim > MAX_DIM) ||
                    ({2'b00, mine_count} >= dim_sq);
    end

    // Encoder looks at the cell about to be presented: 0 when leaving
    // placement, otherwise the one after the cell just acknowledged.
    always_comb begin
        enc_idx = (state == S_PLACE) ? 8'd0 : cell_idx + 8'd1;
        enc_dat = encode_cell(enc_idx, bitmap, dim_q);
    end

    // Main control FSM with registered bus and status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= S_IDLE;
            lfsr            <= LFSR_ALT_SEED;
            bitmap          <= '0;
            placed          <= 8'd0;
            mines_q         <= 8'd0;
            dim_q           <= 5'd0;
            cell_idx        <= 8'd0;
            busy            <= 1'b0;
            done            <= 1'b0;
            error           <= 1'b0;
            master_wr.cyc_o <= 1'b0;
            master_wr.stb_o <= 1'b0;
            master_wr.we_o  <= 1'b0;
            master_wr.adr_o <= 8'd0;
            master_wr.dat_o <= 8'd0;
        end else begin
            done  <= 1'b0;
            error <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (start_bad) begin
                            error <= 1'b1;
                        end else begin
                            dim_q   <= board_dim;
                            mines_q <= mine_count;
                            lfsr    <= (seed == 16'd0) ? LFSR_ALT_SEED : seed;
                            bitmap  <= '0;
                            placed  <= 8'd0;
                            busy    <= 1'b1;
                            state   <= S_PLACE;
                        end
                    end
                end

                S_PLACE: begin
                    // Count is checked before any candidate, so zero mines
                    // leaves after a single cycle.
                    lfsr <= lfsr_next;
                    if (placed == mines_q) begin
                        cell_idx        <= 8'd0;
                        master_wr.cyc_o <= 1'b1;
                        master_wr.stb_o <= 1'b1;
                        master_wr.we_o  <= 1'b1;
                        master_wr.adr_o <= 8'd0;
                        master_wr.dat_o <= enc_dat;
                        state           <= S_WR_REQ;
                    end else if (cand_ok) begin
                        bitmap[cand] <= 1'b1;
                        placed       <= placed + 8'd1;
                    end
                end

                S_WR_REQ: begin
                    // Request stays frozen until the slave stops stalling
                    if (!master_wr.stall_i) begin
                        master_wr.stb_o <= 1'b0;
                        state           <= S_WR_ACK;
                    end
                end

                S_WR_ACK: begin
                    if (master_wr.ack_i) begin
                        if (cell_idx == 8'hFF) begin
                            state <= S_FINISH;
                        end else begin
                            cell_idx        <= cell_idx + 8'd1;
                            master_wr.adr_o <= enc_idx;
                            master_wr.dat_o <= enc_dat;
                            master_wr.stb_o <= 1'b1;
                            state           <= S_WR_REQ;
                        end
                    end
                end

                S_FINISH: begin
                    master_wr.cyc_o <= 1'b0;
                    master_wr.we_o  <= 1'b0;
                    busy            <= 1'b0;
                    done            <= 1'b1;
                    state           <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_board_mine_placer.sv
module tb_board_mine_placer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] seed;
    logic [4:0]  board_dim;
    logic [7:0]  mine_count;
    logic        busy;
    logic        done;
    logic        error;

    wishbone_if wb ();

    board_mine_placer #(
        .BOARD_SIZE   (16),
        .LFSR_ALT_SEED(16'hACE1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .seed      (seed),
        .board_dim (board_dim),
        .mine_count(mine_count),
        .busy      (busy),
        .done      (done),
        .error     (error),
        .master_wr (wb)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    logic [7:0] wr_adr    [4096];
    logic [7:0] wr_dat    [4096];
    logic [7:0] mem       [256];
    logic [7:0] exp_board [256];
    int         wr_total = 0;

    // Board memory: accepts an unstalled strobe, acks one cycle later
    always @(posedge clk) begin
        wb.ack_i <= 1'b0;
        if (rst_n === 1'b1 && wb.cyc_o === 1'b1 && wb.stb_o === 1'b1 &&
            wb.we_o === 1'b1 && wb.stall_i === 1'b0) begin
            if (wr_total < 4096) begin
                wr_adr[wr_total] <= wb.adr_o;
                wr_dat[wr_total] <= wb.dat_o;
            end
            mem[wb.adr_o] <= wb.dat_o;
            wr_total      <= wr_total + 1;
            wb.ack_i      <= 1'b1;
        end
    end

    // Reference board: replay the LFSR, then spread each mine onto its neighbours
    task automatic build_model(input logic [15:0] s, input int dim, input int cnt);
        logic [15:0] l;
        logic [7:0]  cand;
        bit          m [256];
        int          nb [256];
        int          placed;
        int          guard;
        int          r;
        int          c;
        for (int i = 0; i < 256; i++) begin
            m[i]  = 1'b0;
            nb[i] = 0;
        end
        l      = (s == 16'd0) ? 16'hACE1 : s;
        placed = 0;
        guard  = 0;
        while (placed < cnt && guard < 200000) begin
            cand = l[7:0];
            if (int'(cand[7:4]) < dim && int'(cand[3:0]) < dim && !m[cand]) begin
                m[cand] = 1'b1;
                placed++;
            end
            l = l[0] ? ((l >> 1) ^ 16'hB400) : (l >> 1);
            guard++;
        end
        for (int i = 0; i < 256; i++) begin
            if (m[i]) begin
                for (int dr = -1; dr <= 1; dr++) begin
                    for (int dc = -1; dc <= 1; dc++) begin
                        r = i / 16 + dr;
                        c = i % 16 + dc;
                        if ((dr != 0 || dc != 0) && r >= 0 && c >= 0 && r < dim && c < dim)
                            nb[r * 16 + c]++;
                    end
                end
            end
        end
        for (int i = 0; i < 256; i++) begin
            if (i / 16 >= dim || i % 16 >= dim) exp_board[i] = 8'h00;
            else if (m[i])                      exp_board[i] = 8'h80;
            else                                exp_board[i] = 8'(nb[i]);
        end
    endtask

    // Start one board and run to done, optionally stalling one write and
    // poking start/inputs while busy
    task automatic run_board(input logic [15:0] s, input logic [4:0] d, input logic [7:0] mc,
                             input int stall_wr, input int stall_len, input int poke_cyc,
                             output int base, output int cycles, output int dones,
                             output int stall_bad, output int stall_seen, output bit timed_out);
        int         stall_left;
        bit         snap;
        bit         found;
        logic [7:0] sa;
        logic [7:0] sd;
        stall_left = stall_len;
        snap       = 1'b0;
        found      = 1'b0;
        sa         = 8'h00;
        sd         = 8'h00;
        stall_bad  = 0;
        stall_seen = 0;
        dones      = 0;
        cycles     = 0;
        @(negedge clk);
        base       = wr_total;
        seed       = s;
        board_dim  = d;
        mine_count = mc;
        start      = 1'b1;
        while (cycles < 20000 && !found) begin
            @(negedge clk);
            cycles++;
            start = 1'b0;
            if (poke_cyc > 0 && cycles == poke_cyc) begin
                start      = 1'b1;
                seed       = 16'h0001;
                board_dim  = 5'd3;
                mine_count = 8'd1;
            end
            if (stall_wr >= 0 && (wr_total - base) == stall_wr && wb.stb_o === 1'b1) begin
                if (!snap) begin
                    snap = 1'b1;
                    sa   = wb.adr_o;
                    sd   = wb.dat_o;
                end else if (wb.adr_o !== sa || wb.dat_o !== sd) begin
                    stall_bad++;
                end
                if (stall_left > 0) begin
                    wb.stall_i = 1'b1;
                    stall_left--;
                    stall_seen++;
                end else begin
                    wb.stall_i = 1'b0;
                end
            end else begin
                wb.stall_i = 1'b0;
            end
            if (done === 1'b1) begin
                dones++;
                found = 1'b1;
            end
        end
        start      = 1'b0;
        wb.stall_i = 1'b0;
        timed_out  = !found;
        repeat (5) begin
            @(negedge clk);
            if (done === 1'b1) dones++;
        end
    endtask

    task automatic test_reset();
        rst_n      = 1'b0;
        start      = 1'b0;
        seed       = 16'h0000;
        board_dim  = 5'd16;
        mine_count = 8'd0;
        wb.stall_i = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if ({busy, done, error, wb.cyc_o, wb.stb_o, wb.we_o} !== 6'b0) begin
            miscompares++;
            $display("FAIL reset_ctrl: got %b expected 000000",
                     {busy, done, error, wb.cyc_o, wb.stb_o, wb.we_o});
        end
        vectors++;
        if (wb.adr_o !== 8'h00 || wb.dat_o !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_bus: adr %h dat %h expected 00 00", wb.adr_o, wb.dat_o);
        end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        vectors++;
        if (busy !== 1'b0 || wb.cyc_o !== 1'b0) begin
            miscompares++;
            $display("FAIL idle_after_reset: busy %b cyc %b expected 0 0", busy, wb.cyc_o);
        end
    endtask

    task automatic test_zero_mines();
        int base, cycles, dones, sb, ss, bad_order, bad_dat, n;
        bit to;
        run_board(16'h1234, 5'd16, 8'd0, -1, 0, 0, base, cycles, dones, sb, ss, to);
        n = wr_total - base;
        bad_order = 0;
        bad_dat   = 0;
        for (int i = 0; i < 256 && i < n; i++) begin
            if (wr_adr[base + i] !== 8'(i)) bad_order++;
            if (wr_dat[base + i] !== 8'h00) bad_dat++;
        end
        vectors++;
        if (to) begin miscompares++; $display("FAIL zero_timeout: done not seen in %0d cycles", cycles); end
        vectors++;
        if (n !== 256) begin miscompares++; $display("FAIL zero_write_count: got %0d expected 256", n); end
        vectors++;
        if (bad_order !== 0) begin miscompares++; $display("FAIL zero_addr_order: %0d out of order, expected 0", bad_order); end
        vectors++;
        if (bad_dat !== 0) begin miscompares++; $display("FAIL zero_data: %0d nonzero bytes, expected 0", bad_dat); end
        vectors++;
        if (dones !== 1) begin miscompares++; $display("FAIL zero_done_pulses: got %0d expected 1", dones); end
        vectors++;
        if (cycles < 513 || cycles > 517) begin
            miscompares++;
            $display("FAIL zero_latency: got %0d cycles expected 513..517", cycles);
        end
    endtask

    task automatic test_mines40();
        int base, cycles, dones, sb, ss, n, mines;
        bit to;
        build_model(16'hBEEF, 16, 40);
        // start pulse with different inputs lands while busy and must be ignored
        run_board(16'hBEEF, 5'd16, 8'd40, -1, 0, 10, base, cycles, dones, sb, ss, to);
        n = wr_total - base;
        vectors++;
        if (to) begin miscompares++; $display("FAIL m40_timeout: done not seen in %0d cycles", cycles); end
        vectors++;
        if (n !== 256) begin miscompares++; $display("FAIL m40_write_count: got %0d expected 256", n); end
        mines = 0;
        for (int i = 0; i < 256; i++) begin
            if (mem[i] === 8'h80) mines++;
            vectors++;
            if (mem[i] !== exp_board[i]) begin
                miscompares++;
                $display("FAIL m40_cell[%0d]: got %h expected %h", i, mem[i], exp_board[i]);
            end
        end
        vectors++;
        if (mines !== 40) begin miscompares++; $display("FAIL m40_mine_total: got %0d expected 40", mines); end
        vectors++;
        if (mem[0] !== 8'h80 && mem[0] > 8'd3) begin
            miscompares++;
            $display("FAIL m40_corner: got %h expected a count of at most 3", mem[0]);
        end
        vectors++;
        if (dones !== 1) begin miscompares++; $display("FAIL m40_done_pulses: got %0d expected 1", dones); end
    endtask

    task automatic test_dim8();
        int base, cycles, dones, sb, ss, n, mines, outside_bad, col7_bad;
        bit to;
        build_model(16'h5A5A, 8, 10);
        run_board(16'h5A5A, 5'd8, 8'd10, -1, 0, 0, base, cycles, dones, sb, ss, to);
        n = wr_total - base;
        mines = 0;
        outside_bad = 0;
        col7_bad = 0;
        for (int i = 0; i < 256; i++) begin
            if (i / 16 >= 8 || i % 16 >= 8) begin
                if (mem[i] !== 8'h00) outside_bad++;
            end else if (mem[i] === 8'h80) begin
                mines++;
            end
            if (i % 16 == 7 && i / 16 < 8 && mem[i] !== exp_board[i]) col7_bad++;
            vectors++;
            if (mem[i] !== exp_board[i]) begin
                miscompares++;
                $display("FAIL d8_cell[%0d]: got %h expected %h", i, mem[i], exp_board[i]);
            end
        end
        vectors++;
        if (to || n !== 256) begin miscompares++; $display("FAIL d8_run: timeout %0d writes %0d expected 0 256", to, n); end
        vectors++;
        if (outside_bad !== 0) begin miscompares++; $display("FAIL d8_outside: %0d nonzero expected 0", outside_bad); end
        vectors++;
        if (mines !== 10) begin miscompares++; $display("FAIL d8_mines: got %0d expected 10", mines); end
        vectors++;
        if (col7_bad !== 0) begin miscompares++; $display("FAIL d8_col7: %0d wrong expected 0", col7_bad); end
    endtask

    task automatic test_stall();
        int base, cycles, dones, sb, ss, n, bad_order;
        bit to;
        build_model(16'h0F0F, 4, 3);
        run_board(16'h0F0F, 5'd4, 8'd3, 2, 5, 0, base, cycles, dones, sb, ss, to);
        n = wr_total - base;
        bad_order = 0;
        for (int i = 0; i < 256 && i < n; i++)
            if (wr_adr[base + i] !== 8'(i)) bad_order++;
        vectors++;
        if (to) begin miscompares++; $display("FAIL stall_timeout: done not seen in %0d cycles", cycles); end
        vectors++;
        if (ss !== 5) begin miscompares++; $display("FAIL stall_cycles: got %0d expected 5", ss); end
        vectors++;
        if (sb !== 0) begin miscompares++; $display("FAIL stall_hold: %0d changed cycles expected 0", sb); end
        vectors++;
        if (n !== 256) begin miscompares++; $display("FAIL stall_write_count: got %0d expected 256", n); end
        vectors++;
        if (bad_order !== 0) begin miscompares++; $display("FAIL stall_addr_order: %0d out of order expected 0", bad_order); end
        for (int i = 0; i < 256; i++) begin
            vectors++;
            if (mem[i] !== exp_board[i]) begin
                miscompares++;
                $display("FAIL stall_cell[%0d]: got %h expected %h", i, mem[i], exp_board[i]);
            end
        end
    endtask

    task automatic test_rejects();
        int cyc_seen;
        int wr0;
        logic [4:0] dims [2];
        logic [7:0] cnts [2];
        dims[0] = 5'd8;  cnts[0] = 8'd64;
        dims[1] = 5'd1;  cnts[1] = 8'd0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            wr0        = wr_total;
            board_dim  = dims[k];
            mine_count = cnts[k];
            seed       = 16'h1111;
            start      = 1'b1;
            @(negedge clk);
            start = 1'b0;
            vectors++;
            if (error !== 1'b1) begin miscompares++; $display("FAIL reject%0d_error: got %b expected 1", k, error); end
            vectors++;
            if (busy !== 1'b0) begin miscompares++; $display("FAIL reject%0d_busy: got %b expected 0", k, busy); end
            cyc_seen = 0;
            @(negedge clk);
            vectors++;
            if (error !== 1'b0) begin miscompares++; $display("FAIL reject%0d_pulse: got %b expected 0", k, error); end
            repeat (10) begin
                if (wb.cyc_o !== 1'b0 || busy !== 1'b0) cyc_seen++;
                @(negedge clk);
            end
            vectors++;
            if (cyc_seen !== 0 || wr_total !== wr0) begin
                miscompares++;
                $display("FAIL reject%0d_bus: active %0d writes %0d expected 0 0", k, cyc_seen, wr_total - wr0);
            end
        end
    endtask

    task automatic test_reset_restart();
        int base, cycles, dones, sb, ss, n, guard;
        bit to;
        bit hit;
        @(negedge clk);
        seed       = 16'h7777;
        board_dim  = 5'd16;
        mine_count = 8'd5;
        start      = 1'b1;
        hit        = 1'b0;
        guard      = 0;
        while (!hit && guard < 2000) begin
            @(negedge clk);
            start = 1'b0;
            guard++;
            if (wb.cyc_o === 1'b1 && wb.stb_o === 1'b0 && wb.adr_o === 8'd100) hit = 1'b1;
        end
        vectors++;
        if (!hit) begin miscompares++; $display("FAIL rst_reach_cell100: not reached in %0d cycles", guard); end
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({busy, done, error, wb.cyc_o, wb.stb_o, wb.we_o} !== 6'b0 ||
            wb.adr_o !== 8'h00 || wb.dat_o !== 8'h00) begin
            miscompares++;
            $display("FAIL rst_mid_outputs: ctrl %b adr %h dat %h expected all 0",
                     {busy, done, error, wb.cyc_o, wb.stb_o, wb.we_o}, wb.adr_o, wb.dat_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        build_model(16'h0000, 16, 20);
        run_board(16'h0000, 5'd16, 8'd20, -1, 0, 0, base, cycles, dones, sb, ss, to);
        n = wr_total - base;
        vectors++;
        if (to || n !== 256 || dones !== 1) begin
            miscompares++;
            $display("FAIL restart_run: timeout %0d writes %0d dones %0d expected 0 256 1", to, n, dones);
        end
        for (int i = 0; i < 256; i++) begin
            vectors++;
            if (mem[i] !== exp_board[i]) begin
                miscompares++;
                $display("FAIL restart_cell[%0d]: got %h expected %h", i, mem[i], exp_board[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_zero_mines();
        test_mines40();
        test_dim8();
        test_stall();
        test_rejects();
        test_reset_restart();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
